axi_lite_reg_read_slave: RTL and testbench

Read-side AXI-Lite slave that consumes the `axi_lite_read_address_channel` slave modport and returns AXI-Lite read responses from a fixed-latency register-file read port. It decodes and checks each AR beat, issues the register read, and buffers results in an in-order response FIFO. Credit-based flow control keeps `arready` independent of `rready` while sustaining one read per cycle. It sits between the interconnect AR/R channels and the control/status register bank of an SP block.

---
 rtl/axi_lite_pkg.sv | 11 +
 rtl/axi_lite_read_address_channel.sv | 12 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/axi_lite_reg_read_slave.sv | 134 +++++++++++++
 tb/tb_axi_lite_reg_read_slave.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response encoding.
package axi_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
  localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_read_address_channel.sv
// AXI-Lite read address (AR) channel bundle.
interface axi_lite_read_address_channel #(
  parameter int unsigned AXI_ARADDR_WIDTH = 8
);
  logic                        arvalid;
  logic                        arready;
  logic [AXI_ARADDR_WIDTH-1:0] araddr;
  logic [2:0]                  arprot;

  modport master (output arvalid, output araddr, output arprot, input arready);
  modport slave  (input arvalid, input araddr, input arprot, output arready);
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered head; DEPTH need not be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; pointers wrap explicitly at DEPTH-1.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while empty, so no reset is needed.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/axi_lite_reg_read_slave.sv
// AXI-Lite read slave: decodes AR beats, reads a fixed-latency register port and
// returns in-order R responses through a credit-bounded response FIFO.
module axi_lite_reg_read_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned AXI_ARADDR_WIDTH = 8,
  parameter int unsigned AXI_RDATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS         = 16,
  parameter int unsigned REG_READ_LATENCY = 1,
  parameter bit          PRIV_ONLY        = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset,
  axi_lite_read_address_channel.slave   ar,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [AXI_RDATA_WIDTH-1:0]    rdata,
  output logic [1:0]                    rresp,
  output logic                          reg_rd_en,
  output logic [AXI_ARADDR_WIDTH-3:0]   reg_rd_index,
  input  logic [AXI_RDATA_WIDTH-1:0]    reg_rd_data
);
  localparam int unsigned OUT_DEPTH = REG_READ_LATENCY + 2;
  localparam int unsigned CREDIT_W  = $clog2(OUT_DEPTH + 1);
  localparam int unsigned IDX_W     = AXI_ARADDR_WIDTH - 2;
  localparam int unsigned LAT       = REG_READ_LATENCY;
  localparam int unsigned FIFO_W    = AXI_RDATA_WIDTH + 2;

  logic [CREDIT_W-1:0]        credit_q, credit_d;
  logic                       arready;
  logic                       ar_hs, r_hs;
  logic [IDX_W-1:0]           ar_index;
  axi_resp_t                  dec_resp;
  logic [LAT-1:0]             pipe_valid_q;
  axi_resp_t                  pipe_resp_q [LAT];
  logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AXI_RDATA_WIDTH-1:0] push_data;
  logic [FIFO_W-1:0]          fifo_wdata, fifo_rdata;
  logic                       unused_prot;

  // Only arprot[0] (privileged) matters.
  assign unused_prot = ^ar.arprot[2:1];

  // arready depends only on registered credit state.
  assign arready    = !reset && (credit_q < CREDIT_W'(OUT_DEPTH));
  assign ar.arready = arready;
  assign ar_hs      = ar.arvalid && arready;
  assign r_hs       = rvalid && rready;
  assign ar_index   = ar.araddr[AXI_ARADDR_WIDTH-1:2];

  // Decode the AR beat in priority order: SLVERR, then DECERR, then OKAY.
  always_comb begin
    dec_resp = AXI_RESP_OKAY;
    if ((PRIV_ONLY && !ar.arprot[0]) || (ar.araddr[1:0] != 2'b00)) begin
      dec_resp = AXI_RESP_SLVERR;
    end else if ({1'b0, ar_index} >= (IDX_W + 1)'(NUM_REGS)) begin
      dec_resp = AXI_RESP_DECERR;
    end
  end

  assign reg_rd_en    = ar_hs && (dec_resp == AXI_RESP_OKAY);
  assign reg_rd_index = ar_index;

  // Outstanding reads: +1 per AR handshake, -1 per R handshake.
  always_comb begin
    credit_d = credit_q;
    if (ar_hs && !r_hs) begin
      credit_d = credit_q + CREDIT_W'(1);
    end else if (!ar_hs && r_hs) begin
      credit_d = credit_q - CREDIT_W'(1);
    end
  end

  // Credit counter state.
  always_ff @(posedge clock) begin
    if (reset) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  // Tracking pipeline aligned with the register read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        pipe_resp_q[i] <= AXI_RESP_OKAY;
      end
    end else begin
      pipe_valid_q[0] <= ar_hs;
      pipe_resp_q[0]  <= dec_resp;
      for (int unsigned i = 1; i < LAT; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_resp_q[i]  <= pipe_resp_q[i-1];
      end
    end
  end

  // Error responses carry zero data; register data is only meaningful for OKAY.
  always_comb begin
    push_data = '0;
    if (pipe_resp_q[LAT-1] == AXI_RESP_OKAY) begin
      push_data = reg_rd_data;
    end
  end

  assign fifo_push  = pipe_valid_q[LAT-1];
  assign fifo_wdata = {pipe_resp_q[LAT-1], push_data};
  assign fifo_pop   = r_hs;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (OUT_DEPTH)
  ) u_resp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head is forced to zero while empty so idle R outputs are clean.
  assign rvalid = !fifo_empty;
  assign rresp  = rvalid ? fifo_rdata[FIFO_W-1 -: 2] : AXI_RESP_OKAY;
  assign rdata  = rvalid ? fifo_rdata[AXI_RDATA_WIDTH-1:0] : '0;

  // Credits bound occupancy, so a push into a full FIFO means broken accounting.
  assert property (@(posedge clock) disable iff (reset) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_axi_lite_reg_read_slave.sv
// Bench: two slaves (PRIV_ONLY=0 and 1) driven with identical AR/R stimulus,
// checked cycle by cycle against a credit/latency scoreboard.
module tb_axi_lite_reg_read_slave;
  import axi_lite_pkg::*;

  typedef struct {
    logic [7:0] addr;
    logic [2:0] prot;
    axi_resp_t  resp0;
    axi_resp_t  resp1;
  } vec_t;

  typedef struct {
    int          acc;
    logic [31:0] data0;
    axi_resp_t   resp0;
    logic [31:0] data1;
    axi_resp_t   resp1;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        arvalid_s;
  logic [7:0]  araddr_s;
  logic [2:0]  arprot_s;
  logic        rready_s;
  logic [31:0] rd_data_s;

  logic        rvalid0, rvalid1, en0, en1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  rresp0, rresp1;
  logic [5:0]  idx0, idx1;

  logic [31:0] regs [16];
  ent_t        q [$];
  vec_t        cur_v;
  vec_t        tbl [10];
  int          credit_m, last_pop, cyc;
  bit          hs_flag;
  int          total, bad;

  always #5 clock = ~clock;

  axi_lite_read_address_channel #(.AXI_ARADDR_WIDTH(8)) ar0 ();
  axi_lite_read_address_channel #(.AXI_ARADDR_WIDTH(8)) ar1 ();

  assign ar0.arvalid = arvalid_s;
  assign ar0.araddr  = araddr_s;
  assign ar0.arprot  = arprot_s;
  assign ar1.arvalid = arvalid_s;
  assign ar1.araddr  = araddr_s;
  assign ar1.arprot  = arprot_s;

  axi_lite_reg_read_slave #(
    .AXI_ARADDR_WIDTH (8),
    .AXI_RDATA_WIDTH  (32),
    .NUM_REGS         (16),
    .REG_READ_LATENCY (1),
    .PRIV_ONLY        (1'b0)
  ) u_dut0 (
    .clock        (clock),
    .reset        (reset),
    .ar           (ar0),
    .rvalid       (rvalid0),
    .rready       (rready_s),
    .rdata        (rdata0),
    .rresp        (rresp0),
    .reg_rd_en    (en0),
    .reg_rd_index (idx0),
    .reg_rd_data  (rd_data_s)
  );

  axi_lite_reg_read_slave #(
    .AXI_ARADDR_WIDTH (8),
    .AXI_RDATA_WIDTH  (32),
    .NUM_REGS         (16),
    .REG_READ_LATENCY (1),
    .PRIV_ONLY        (1'b1)
  ) u_dut1 (
    .clock        (clock),
    .reset        (reset),
    .ar           (ar1),
    .rvalid       (rvalid1),
    .rready       (rready_s),
    .rdata        (rdata1),
    .rresp        (rresp1),
    .reg_rd_en    (en1),
    .reg_rd_index (idx1),
    .reg_rd_data  (rd_data_s)
  );

  // Register file responder with one cycle of latency; garbage when not read.
  always @(posedge clock) begin
    rd_data_s <= (en0 && idx0 < 6'd16) ? regs[idx0[3:0]] : 32'hBAD0_BAD0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard/monitor, sampled mid-cycle.
  always @(negedge clock) begin
    logic exp_ar, mhs, mv, mrhs, exp_en0, exp_en1;
    int   due;
    ent_t e;
    cyc++;
    if (reset) begin
      chk("reset_arready0", ar0.arready, 1'b0);
      chk("reset_arready1", ar1.arready, 1'b0);
      chk("reset_rd_en0", en0, 1'b0);
      chk("reset_rd_en1", en1, 1'b0);
      q.delete();
      credit_m = 0;
      last_pop = -100;
      hs_flag  = 1'b0;
    end else begin
      exp_ar = (credit_m < 3);
      chk("arready0", ar0.arready, exp_ar);
      chk("arready1", ar1.arready, exp_ar);
      mhs     = arvalid_s && exp_ar;
      exp_en0 = mhs && (cur_v.resp0 == AXI_RESP_OKAY);
      exp_en1 = mhs && (cur_v.resp1 == AXI_RESP_OKAY);
      chk("reg_rd_en0", en0, exp_en0);
      chk("reg_rd_en1", en1, exp_en1);
      if (exp_en0) chk("reg_rd_index0", idx0, cur_v.addr[7:2]);
      if (exp_en1) chk("reg_rd_index1", idx1, cur_v.addr[7:2]);
      mv = 1'b0;
      if (q.size() > 0) begin
        due = q[0].acc + 2;
        if (last_pop + 1 > due) due = last_pop + 1;
        mv = (cyc >= due);
      end
      chk("rvalid0", rvalid0, mv);
      chk("rvalid1", rvalid1, mv);
      if (mv) begin
        chk("rdata0", rdata0, q[0].data0);
        chk("rresp0", rresp0, q[0].resp0);
        chk("rdata1", rdata1, q[0].data1);
        chk("rresp1", rresp1, q[0].resp1);
      end
      mrhs = mv && rready_s;
      if (mrhs) begin
        void'(q.pop_front());
        last_pop = cyc;
      end
      if (mhs) begin
        e.acc   = cyc;
        e.resp0 = cur_v.resp0;
        e.resp1 = cur_v.resp1;
        e.data0 = (cur_v.resp0 == AXI_RESP_OKAY) ? regs[cur_v.addr[5:2]] : 32'h0;
        e.data1 = (cur_v.resp1 == AXI_RESP_OKAY) ? regs[cur_v.addr[5:2]] : 32'h0;
        q.push_back(e);
      end
      credit_m = credit_m + (mhs ? 1 : 0) - (mrhs ? 1 : 0);
      hs_flag  = mhs;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold arvalid until the model sees the handshake; starts and ends at posedge+1.
  task automatic send(input vec_t v);
    int n;
    n         = 0;
    cur_v     = v;
    arvalid_s = 1'b1;
    araddr_s  = v.addr;
    arprot_s  = v.prot;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!hs_flag && n < 100);
    if (!hs_flag) begin
      total++;
      bad++;
      $display("FAIL ar_accept_timeout: got no handshake expected one for addr %h", v.addr);
    end
    arvalid_s = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; credit_m = 0; last_pop = -100; hs_flag = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 32'hC0DE_0000 | 32'(i * 32'h111);
    regs[2] = 32'hDEAD_BEEF;
    cur_v = '{8'h00, 3'b000, AXI_RESP_OKAY, AXI_RESP_OKAY};

    tbl[0] = '{8'h05, 3'b001, AXI_RESP_SLVERR, AXI_RESP_SLVERR};
    tbl[1] = '{8'h04, 3'b000, AXI_RESP_OKAY,   AXI_RESP_SLVERR};
    tbl[2] = '{8'h40, 3'b001, AXI_RESP_DECERR, AXI_RESP_DECERR};
    tbl[3] = '{8'h40, 3'b000, AXI_RESP_DECERR, AXI_RESP_SLVERR};
    tbl[4] = '{8'h41, 3'b001, AXI_RESP_SLVERR, AXI_RESP_SLVERR};
    tbl[5] = '{8'hFC, 3'b111, AXI_RESP_DECERR, AXI_RESP_DECERR};
    tbl[6] = '{8'h3C, 3'b110, AXI_RESP_OKAY,   AXI_RESP_SLVERR};
    tbl[7] = '{8'h3C, 3'b101, AXI_RESP_OKAY,   AXI_RESP_OKAY};
    tbl[8] = '{8'h02, 3'b001, AXI_RESP_SLVERR, AXI_RESP_SLVERR};
    tbl[9] = '{8'h24, 3'b001, AXI_RESP_OKAY,   AXI_RESP_OKAY};

    reset = 1'b1; arvalid_s = 1'b0; araddr_s = '0; arprot_s = '0; rready_s = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("post_reset_rvalid0", rvalid0, 1'b0);
    chk("post_reset_rdata0", rdata0, 32'h0);
    chk("post_reset_rresp0", rresp0, 2'b00);
    chk("post_reset_rvalid1", rvalid1, 1'b0);
    idle(1);

    // Single read of index 2.
    send('{8'h08, 3'b000, AXI_RESP_OKAY, AXI_RESP_SLVERR});
    idle(4);

    // Decode table, isolated reads.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i]);
      idle(3);
    end

    // Streaming: 8 back-to-back reads.
    for (int i = 0; i < 8; i++) send('{8'(i * 4), 3'b001, AXI_RESP_OKAY, AXI_RESP_OKAY});
    idle(6);

    // Backpressure: only 3 accepted while rready is low; head holds.
    rready_s = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send('{8'(8'h10 + i * 4), 3'b001, AXI_RESP_OKAY, AXI_RESP_OKAY});
      end
      begin
        repeat (7) @(posedge clock);
        @(negedge clock);
        chk("bp_arready_low", ar0.arready, 1'b0);
        chk("bp_head_valid", rvalid0, 1'b1);
        chk("bp_head_data", rdata0, regs[4]);
        @(posedge clock);
        #1 rready_s = 1'b1;
      end
    join
    idle(8);

    // Reset with two reads in flight; arvalid held high through reset.
    rready_s = 1'b0;
    send('{8'h0C, 3'b001, AXI_RESP_OKAY, AXI_RESP_OKAY});
    send('{8'h20, 3'b001, AXI_RESP_OKAY, AXI_RESP_OKAY});
    reset = 1'b1; arvalid_s = 1'b1; araddr_s = 8'h00; arprot_s = 3'b001;
    @(negedge clock);
    chk("midreset_arready", ar0.arready, 1'b0);
    chk("midreset_rd_en", en0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0; arvalid_s = 1'b0; rready_s = 1'b1;
    @(negedge clock);
    chk("after_reset_rvalid0", rvalid0, 1'b0);
    chk("after_reset_rvalid1", rvalid1, 1'b0);
    idle(5);
    send('{8'h2C, 3'b001, AXI_RESP_OKAY, AXI_RESP_OKAY});
    idle(5);

    for (int k = 0; k < 50 && q.size() > 0; k++) @(posedge clock);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d responses pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
